// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a frame-aligned double-buffered digit register.
// Define SCAN_BLANK_EN to compile in the per-slot blanking gap (BLANK state).
module display_scan_ctrl #(
   parameter int CLK_HZ       = 27000000,
   parameter int SCAN_HZ      = 1000,
   parameter int N_DIGITS     = 4,
   parameter int BLANK_CYCLES = 270
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [4*N_DIGITS-1:0] data_i,
   output logic                  ready_o,
   output logic [N_DIGITS-1:0]   anode_o,
   output logic [3:0]            digit_o,
   output logic                  frame_o
);

   localparam int DIV   = CLK_HZ / SCAN_HZ;
   localparam int CNT_W = $clog2(DIV);
   localparam int IDX_W = $clog2(N_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

`ifdef SCAN_BLANK_EN
   localparam bit PARAM_OK = (DIV >= 2) && (N_DIGITS >= 2) &&
                             (BLANK_CYCLES >= 1) && (BLANK_CYCLES < DIV);
   localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(DIV - BLANK_CYCLES - 1);

   typedef enum logic {SHOW, BLANK} state_t;
   state_t state_q, state_d;
`else
   localparam bit PARAM_OK = (DIV >= 2) && (N_DIGITS >= 2) && (BLANK_CYCLES >= 0);
`endif

   if (!PARAM_OK) begin : g_bad_params
      $error("display_scan_ctrl: illegal parameter combination");
   end

   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [N_DIGITS-1:0][3:0]    active_q, active_d;
   logic [N_DIGITS-1:0][3:0]    pend_q, pend_d;
   logic                        pend_valid_q, pend_valid_d;
   logic [N_DIGITS-1:0]         anode_q, anode_d;
   logic [3:0]                  digit_q, digit_d;
   logic                        frame_q, frame_d;
   logic                        wrap, boundary, accept, lit;

   always_comb begin
      wrap     = (cnt_q == CNT_LAST);
      boundary = wrap && (idx_q == IDX_LAST);
      accept   = load_i && !pend_valid_q;

      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      idx_d = idx_q;
      if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      // Transfer and accept are exclusive: accept needs an empty buffer, transfer a full one.
      active_d     = active_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      if (boundary && pend_valid_q) begin
         active_d     = pend_q;
         pend_valid_d = 1'b0;
      end else if (accept) begin
         pend_d       = data_i;
         pend_valid_d = 1'b1;
      end

`ifdef SCAN_BLANK_EN
      state_d = state_q;
      case (state_q)
         SHOW:    if (cnt_q == SHOW_LAST) state_d = BLANK;
         BLANK:   if (wrap)               state_d = SHOW;
         default:                         state_d = SHOW;
      endcase
      lit = (state_d == SHOW);
`else
      lit = 1'b1;
`endif

      // Outputs are registered from next-cycle state so they line up with cnt/idx.
      frame_d = boundary;
      anode_d = lit ? ~(N_DIGITS'(1) << idx_d) : '1;
      digit_d = lit ? active_d[idx_d] : digit_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         active_q     <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         anode_q      <= '1;
         digit_q      <= '0;
         frame_q      <= 1'b0;
`ifdef SCAN_BLANK_EN
         state_q      <= SHOW;
`endif
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         anode_q      <= anode_d;
         digit_q      <= digit_d;
         frame_q      <= frame_d;
`ifdef SCAN_BLANK_EN
         state_q      <= state_d;
`endif
      end
   end

   assign ready_o = ~pend_valid_q;
   assign anode_o = anode_q;
   assign digit_o = digit_q;
   assign frame_o = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: constant vector table, directed corner sequences, random loads vs a time-based model.
module tb_display_scan_ctrl;
   localparam int CLK_HZ = 1000;
   localparam int SCAN_HZ = 100;
   localparam int N = 4;
   localparam int BLANK = 2;
   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int FRAME = DIV * N;
`ifdef SCAN_BLANK_EN
   localparam bit BLK_EN = 1'b1;
   localparam logic [3:0] AN_GAP = 4'hF;
`else
   localparam bit BLK_EN = 1'b0;
   localparam logic [3:0] AN_GAP = 4'hE;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_i = 1'b0;
   logic [15:0] data_i = '0;
   logic        ready_o;
   logic [3:0]  anode_o;
   logic [3:0]  digit_o;
   logic        frame_o;

   display_scan_ctrl #(
      .CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .N_DIGITS(N), .BLANK_CYCLES(BLANK)
   ) dut (
      .clk(clk), .rst(rst), .load_i(load_i), .data_i(data_i),
      .ready_o(ready_o), .anode_o(anode_o), .digit_o(digit_o), .frame_o(frame_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: t = edges since reset release; slot/digit derived arithmetically.
   int          t;
   logic [15:0] m_active, m_pend;
   bit          m_pv;
   logic [3:0]  m_digit, m_anode;
   bit          m_frame;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0d)", nm, act, exp, t);
      end
   endtask

   task automatic model_reset();
      t = 0; m_active = '0; m_pend = '0; m_pv = 1'b0; m_digit = '0; m_frame = 1'b0;
   endtask

   task automatic step(input bit ld, input logic [15:0] d);
      int c, dsel;
      bit blank;
      logic [3:0] one;
      load_i = ld;
      data_i = d;
      @(posedge clk);
      #1;
      load_i = 1'b0;
      t++;
      m_frame = (t % FRAME) == 0;
      if (m_frame && m_pv) begin
         m_active = m_pend;
         m_pv = 1'b0;
      end else if (ld && !m_pv) begin
         m_pend = d;
         m_pv = 1'b1;
      end
      c = t % DIV;
      dsel = (t / DIV) % N;
      blank = BLK_EN && (c >= DIV - BLANK);
      one = 4'b0001;
      m_anode = blank ? 4'hF : ~(one << dsel);
      if (!blank) m_digit = 4'((m_active >> (4 * dsel)) & 16'hF);
   endtask

   task automatic check_model();
      chk("anode", 16'(anode_o), 16'(m_anode));
      chk("digit", 16'(digit_o), 16'(m_digit));
      chk("ready", 16'(ready_o), 16'(!m_pv));
      chk("frame", 16'(frame_o), 16'(m_frame));
   endtask

   task automatic run_to(input int tt);
      while (t < tt) begin
         step(1'b0, 16'h0);
         check_model();
      end
   endtask

   typedef struct {
      bit          ld;
      logic [15:0] dat;
      logic [3:0]  an;
      logic [3:0]  dg;
      bit          rdy;
      bit          frm;
   } vec_t;
   vec_t tbl[12];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Edges 1..12 after release; a load of 4321 on edge 5.
      for (int i = 0; i < 12; i++) begin
         tbl[i].ld  = (i == 4);
         tbl[i].dat = (i == 4) ? 16'h4321 : 16'h0;
         tbl[i].an  = (i < 7) ? 4'hE : (i < 9) ? AN_GAP : 4'hD;
         tbl[i].dg  = 4'h0;
         tbl[i].rdy = (i < 4);
         tbl[i].frm = 1'b0;
      end

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_anode", 16'(anode_o), 16'hF);
      chk("rst_digit", 16'(digit_o), 16'h0);
      chk("rst_ready", 16'(ready_o), 16'h1);
      chk("rst_frame", 16'(frame_o), 16'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         step(tbl[i].ld, tbl[i].dat);
         chk("tbl_anode", 16'(anode_o), 16'(tbl[i].an));
         chk("tbl_digit", 16'(digit_o), 16'(tbl[i].dg));
         chk("tbl_ready", 16'(ready_o), 16'(tbl[i].rdy));
         chk("tbl_frame", 16'(frame_o), 16'(tbl[i].frm));
      end

      // Load while full is dropped.
      run_to(19);
      step(1'b1, 16'hAAAA);
      check_model();
      chk("full_ready", 16'(ready_o), 16'h0);
      run_to(40);
      chk("bnd_frame", 16'(frame_o), 16'h1);
      chk("bnd_ready", 16'(ready_o), 16'h1);
      run_to(41); chk("f1_d0", 16'(digit_o), 16'h1); chk("f1_a0", 16'(anode_o), 16'hE);
      run_to(51); chk("f1_d1", 16'(digit_o), 16'h2); chk("f1_a1", 16'(anode_o), 16'hD);
      run_to(61); chk("f1_d2", 16'(digit_o), 16'h3); chk("f1_a2", 16'(anode_o), 16'hB);
      run_to(71); chk("f1_d3", 16'(digit_o), 16'h4); chk("f1_a3", 16'(anode_o), 16'h7);

      // Load on the boundary edge with an empty buffer waits a full frame.
      run_to(79);
      step(1'b1, 16'h5678);
      check_model();
      chk("bl_digit_old", 16'(digit_o), 16'h1);
      chk("bl_ready", 16'(ready_o), 16'h0);
      run_to(120);
      chk("bl_digit_new", 16'(digit_o), 16'h8);
      chk("bl_ready2", 16'(ready_o), 16'h1);

      // Async reset mid-slot of digit 2 with a load pending.
      run_to(124);
      step(1'b1, 16'h9ABC);
      check_model();
      run_to(145);
      #2 rst = 1'b1;
      #1;
      chk("mrst_anode", 16'(anode_o), 16'hF);
      chk("mrst_ready", 16'(ready_o), 16'h1);
      chk("mrst_digit", 16'(digit_o), 16'h0);
      chk("mrst_frame", 16'(frame_o), 16'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step(1'b0, 16'h0);
      chk("rel_anode", 16'(anode_o), 16'hE);
      chk("rel_digit", 16'(digit_o), 16'h0);
      run_to(41);
      chk("lost_load", 16'(digit_o), 16'h0);

      // Random loads against the model.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 5) == 0, 16'($urandom));
         check_model();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
